irq_exc_sequencer: RTL and testbench



---
 rtl/irq_seq_pkg.sv | 28 ++
 rtl/irq_exc_sequencer_prio_enc.sv | 24 ++
 rtl/irq_exc_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_irq_exc_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_seq_pkg.sv
// Shared types and CAUSE field layout for the interrupt/exception entry sequencer.
package irq_seq_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ARB       = 3'd1,
        TAKE_SYNC = 3'd2,
        TAKE_INT  = 3'd3,
        SERVICE   = 3'd4
    } state_t;

    localparam int          CAUSE_INT_BIT  = 31;
    localparam int          CAUSE_IP_LSB   = 8;
    localparam int          CAUSE_CODE_LSB = 2;
    localparam logic [4:0]  EXC_CODE_INT   = 5'd0;

    function automatic logic [31:0] make_cause(input logic is_int,
                                               input logic [4:0] ip,
                                               input logic [4:0] code);
        logic [31:0] c;
        c = 32'd0;
        c[CAUSE_INT_BIT]            = is_int;
        c[CAUSE_IP_LSB +: 5]        = ip;
        c[CAUSE_CODE_LSB +: 5]      = code;
        return c;
    endfunction

endpackage

// File: rtl/irq_exc_sequencer_prio_enc.sv
// Masked find-first-set: lowest set bit of (req & mask) wins.
module irq_prio_enc #(
    parameter int N = 5
) (
    input  logic [N-1:0] req,
    input  logic [N-1:0] mask,
    output logic [4:0]   idx,
    output logic         valid
);

    logic [N-1:0] masked_s;

    assign masked_s = req & mask;

    // Walk from the top so the lowest index is the last one written.
    always_comb begin
        idx   = 5'd0;
        valid = |masked_s;
        for (int i = N - 1; i >= 0; i--) begin
            idx = masked_s[i] ? 5'(i) : idx;
        end
    end

endmodule

// File: rtl/irq_exc_sequencer.sv
// Exception/interrupt entry sequencer feeding CP0 and the fetch redirect.
// Build option IRQ_EDGE_EN: edge-triggered pending flops instead of level requests.
module irq_exc_sequencer
    import irq_seq_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    NUM_IRQ    = 5,
    parameter int                    IRQ_BASE   = 0,
    parameter logic [ADDR_WIDTH-1:0] VECTOR     = 32'h0000_0040
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_IRQ-1:0]    int_req,
    input  logic                  exc_req,
    input  logic [4:0]            exc_code,
    input  logic [ADDR_WIDTH-1:0] exc_pc,
    input  logic                  commit_valid,
    input  logic [ADDR_WIDTH-1:0] commit_pc,
    input  logic                  eret,
    input  logic                  int_permit,
    output logic [4:0]            int_device,
    output logic                  exception,
    output logic [DATA_WIDTH-1:0] cause,
    output logic [ADDR_WIDTH-1:0] epc,
    output logic                  redirect,
    output logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic [NUM_IRQ-1:0]    int_ack,
    output logic                  in_service
);

    state_t                  state_r, state_n;
    logic [NUM_IRQ-1:0]      pending_s;
    logic [NUM_IRQ-1:0]      mask_r, mask_n;
    logic [NUM_IRQ-1:0]      enc_mask_s;
    logic [NUM_IRQ-1:0]      cand_onehot_s;
    logic [NUM_IRQ+4:0]      pend_pad_s;
    logic [4:0]              cand_r, cand_n;
    logic [4:0]              code_r, code_n;
    logic [4:0]              enc_idx_s;
    logic [4:0]              ip_s;
    logic [4:0]              fire_code_s;
    logic                    enc_valid_s;
    logic                    cand_pending_s;
    logic                    fire_s;
    logic                    fire_int_s;
    logic [ADDR_WIDTH-1:0]   xpc_r, xpc_n;
    logic [ADDR_WIDTH-1:0]   fire_pc_s;

`ifdef IRQ_EDGE_EN
    logic [NUM_IRQ-1:0]      pend_r;
    logic [NUM_IRQ-1:0]      req_d_r;

    // Rising edges set a line; the visible ack clears it, but a new edge in that cycle wins.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pend_r  <= '0;
            req_d_r <= '0;
        end else begin
            pend_r  <= (pend_r & ~int_ack) | (int_req & ~req_d_r);
            req_d_r <= int_req;
        end
    end

    assign pending_s = pend_r;
`else
    assign pending_s = int_req;
`endif

    assign cand_onehot_s  = NUM_IRQ'(1'b1) << cand_r;
    assign cand_pending_s = |(pending_s & cand_onehot_s);
    assign enc_mask_s     = (state_r == ARB) ? (mask_r & ~cand_onehot_s) : {NUM_IRQ{1'b1}};
    assign pend_pad_s     = (NUM_IRQ + 5)'(pending_s);
    assign ip_s           = pend_pad_s[4:0];

    irq_prio_enc #(.N(NUM_IRQ)) u_prio_enc (
        .req   (pending_s),
        .mask  (enc_mask_s),
        .idx   (enc_idx_s),
        .valid (enc_valid_s)
    );

    // Next-state and fire decision; the encoder already sees the scan mask for the next candidate.
    always_comb begin
        state_n     = state_r;
        mask_n      = mask_r;
        cand_n      = cand_r;
        code_n      = code_r;
        xpc_n       = xpc_r;
        fire_s      = 1'b0;
        fire_int_s  = 1'b0;
        fire_code_s = code_r;
        fire_pc_s   = xpc_r;
        case (state_r)
            IDLE: begin
                if (exc_req) begin
                    code_n  = exc_code;
                    xpc_n   = exc_pc;
                    state_n = TAKE_SYNC;
                end else if (enc_valid_s) begin
                    mask_n  = {NUM_IRQ{1'b1}};
                    cand_n  = enc_idx_s;
                    state_n = ARB;
                end else begin
                    state_n = IDLE;
                end
            end
            ARB: begin
                if (exc_req) begin
                    code_n  = exc_code;
                    xpc_n   = exc_pc;
                    state_n = TAKE_SYNC;
                end else if (cand_pending_s && int_permit) begin
                    state_n = TAKE_INT;
                end else begin
                    mask_n = enc_mask_s;
                    if (enc_valid_s) begin
                        cand_n = enc_idx_s;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            TAKE_SYNC: begin
                fire_s  = 1'b1;
                state_n = SERVICE;
            end
            TAKE_INT: begin
                if (exc_req) begin
                    code_n  = exc_code;
                    xpc_n   = exc_pc;
                    state_n = TAKE_SYNC;
                end else if (!cand_pending_s) begin
                    state_n = IDLE;
                end else if (commit_valid) begin
                    fire_s     = 1'b1;
                    fire_int_s = 1'b1;
                    fire_pc_s  = commit_pc;
                    state_n    = SERVICE;
                end else begin
                    state_n = TAKE_INT;
                end
            end
            SERVICE: begin
                if (exc_req) begin
                    fire_s      = 1'b1;
                    fire_code_s = exc_code;
                    fire_pc_s   = exc_pc;
                end else if (eret) begin
                    state_n = IDLE;
                end else begin
                    state_n = SERVICE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State, latched context and registered CP0/fetch outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r     <= IDLE;
            mask_r      <= '0;
            cand_r      <= 5'd0;
            code_r      <= 5'd0;
            xpc_r       <= '0;
            exception   <= 1'b0;
            redirect    <= 1'b0;
            int_ack     <= '0;
            cause       <= '0;
            epc         <= '0;
            in_service  <= 1'b0;
            int_device  <= 5'd0;
            redirect_pc <= VECTOR;
        end else begin
            state_r     <= state_n;
            mask_r      <= mask_n;
            cand_r      <= cand_n;
            code_r      <= code_n;
            xpc_r       <= xpc_n;
            exception   <= fire_s;
            redirect    <= fire_s;
            int_ack     <= fire_int_s ? cand_onehot_s : '0;
            cause       <= fire_s ? DATA_WIDTH'(make_cause(fire_int_s,
                                                           fire_int_s ? ip_s : 5'd0,
                                                           fire_int_s ? EXC_CODE_INT : fire_code_s))
                                  : '0;
            epc         <= fire_s ? fire_pc_s : '0;
            in_service  <= (state_n == SERVICE);
            int_device  <= 5'(IRQ_BASE) + cand_n;
            redirect_pc <= VECTOR;
        end
    end

endmodule

// File: tb/tb_irq_exc_sequencer.sv
// Scoreboard bench: a behavioural model queues expected CP0 entries, a monitor pops them on each exception strobe.
module tb_irq_exc_sequencer;

    localparam int          NUM_IRQ  = 5;
    localparam int          IRQ_BASE = 0;
    localparam logic [31:0] VEC      = 32'h0000_0040;

    localparam int P_IDLE = 0, P_ARB = 1, P_TS = 2, P_TI = 3, P_SVC = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  int_req;
    logic        exc_req;
    logic [4:0]  exc_code;
    logic [31:0] exc_pc;
    logic        commit_valid;
    logic [31:0] commit_pc;
    logic        eret;
    logic        int_permit;
    logic [4:0]  int_device;
    logic        exception;
    logic [31:0] cause;
    logic [31:0] epc;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [4:0]  int_ack;
    logic        in_service;
    logic [31:0] permit_mask;

    always #5 clk = ~clk;

    assign int_permit = permit_mask[int_device];

    irq_exc_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .int_req      (int_req),
        .exc_req      (exc_req),
        .exc_code     (exc_code),
        .exc_pc       (exc_pc),
        .commit_valid (commit_valid),
        .commit_pc    (commit_pc),
        .eret         (eret),
        .int_permit   (int_permit),
        .int_device   (int_device),
        .exception    (exception),
        .cause        (cause),
        .epc          (epc),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .int_ack      (int_ack),
        .in_service   (in_service)
    );

    typedef struct {
        int          cyc;
        logic [31:0] cause;
        logic [31:0] epc;
        logic [4:0]  ack;
    } fire_t;

    fire_t exp_q[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc    = 0;

    int          ph         = P_IDLE;
    int          m_cand     = 0;
    logic [4:0]  m_mask     = 5'd0;
    logic [4:0]  m_code     = 5'd0;
    logic [31:0] m_pc       = 32'd0;
    logic [4:0]  m_pend_r   = 5'd0;
    logic [4:0]  m_req_d    = 5'd0;
    logic [4:0]  m_ack_last = 5'd0;
    bit          m_insvc    = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int ffs(input logic [4:0] v);
        for (int i = 0; i < 5; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    // Reference model: applies the entry rules to the inputs seen at each rising edge.
    always @(posedge clk) begin : model
        logic [4:0] pend;
        fire_t      f;
        bit         fire;
        cyc     = cyc + 1;
        fire    = 1'b0;
        f.cyc   = cyc;
        f.cause = 32'd0;
        f.epc   = 32'd0;
        f.ack   = 5'd0;
        if (!rst) begin
            ph = P_IDLE; m_cand = 0; m_mask = 5'd0;
            m_pend_r = 5'd0; m_req_d = 5'd0; m_ack_last = 5'd0;
        end else begin
`ifdef IRQ_EDGE_EN
            pend = m_pend_r;
`else
            pend = int_req;
`endif
            case (ph)
                P_IDLE: begin
                    if (exc_req) begin
                        m_code = exc_code; m_pc = exc_pc; ph = P_TS;
                    end else if (pend != 5'd0) begin
                        m_mask = 5'h1f; m_cand = ffs(pend); ph = P_ARB;
                    end
                end
                P_ARB: begin
                    if (exc_req) begin
                        m_code = exc_code; m_pc = exc_pc; ph = P_TS;
                    end else if (pend[m_cand] && permit_mask[m_cand + IRQ_BASE]) begin
                        ph = P_TI;
                    end else begin
                        m_mask[m_cand] = 1'b0;
                        if ((pend & m_mask) == 5'd0) ph = P_IDLE;
                        else m_cand = ffs(pend & m_mask);
                    end
                end
                P_TS: begin
                    fire = 1'b1; f.cause = 32'(m_code) << 2; f.epc = m_pc; ph = P_SVC;
                end
                P_TI: begin
                    if (exc_req) begin
                        m_code = exc_code; m_pc = exc_pc; ph = P_TS;
                    end else if (!pend[m_cand]) begin
                        ph = P_IDLE;
                    end else if (commit_valid) begin
                        fire    = 1'b1;
                        f.cause = 32'h8000_0000 | (32'(pend) << 8);
                        f.epc   = commit_pc;
                        f.ack   = 5'd1 << m_cand;
                        ph      = P_SVC;
                    end
                end
                P_SVC: begin
                    if (exc_req) begin
                        fire = 1'b1; f.cause = 32'(exc_code) << 2; f.epc = exc_pc;
                    end else if (eret) begin
                        ph = P_IDLE;
                    end
                end
                default: ph = P_IDLE;
            endcase
            m_pend_r   = (m_pend_r & ~m_ack_last) | (int_req & ~m_req_d);
            m_req_d    = int_req;
            m_ack_last = f.ack;
            if (fire) exp_q.push_back(f);
        end
        m_insvc = (ph == P_SVC);
    end

    // Monitor: pops the scoreboard on every exception strobe, checks quiet outputs otherwise.
    always @(posedge clk) begin : monitor
        fire_t e;
        #1;
        if (exception) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_fire: got exception cause %0h epc %0h expected none (cycle %0d)",
                         cause, epc, cyc);
            end else begin
                e = exp_q.pop_front();
                check("fire_cycle", 64'(cyc), 64'(e.cyc));
                check("cause", 64'(cause), 64'(e.cause));
                check("epc", 64'(epc), 64'(e.epc));
                check("int_ack", 64'(int_ack), 64'(e.ack));
                check("redirect", 64'(redirect), 64'd1);
            end
        end else begin
            if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
                e = exp_q.pop_front();
                checks++; errors++;
                $display("FAIL missing_fire: got no exception expected cause %0h at cycle %0d", e.cause, e.cyc);
            end
            check("quiet_ack_redirect", 64'({int_ack, redirect}), 64'd0);
        end
        check("in_service", 64'(in_service), 64'(m_insvc));
        if (ph == P_ARB) check("int_device", 64'(int_device), 64'(m_cand + IRQ_BASE));
        check("redirect_pc", 64'(redirect_pc), 64'(VEC));
    end

    task automatic eret_pulse();
        @(negedge clk); int_req = 5'd0; eret = 1'b1;
        @(negedge clk); eret = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        bit seen;
        rst = 1'b0; int_req = 5'd0; exc_req = 1'b0; exc_code = 5'd0; exc_pc = 32'd0;
        commit_valid = 1'b0; commit_pc = 32'd0; eret = 1'b0; permit_mask = 32'd0;
        repeat (3) @(negedge clk);
        check("rst_exception", 64'(exception), 64'd0);
        check("rst_cause", 64'(cause), 64'd0);
        check("rst_int_device", 64'(int_device), 64'd0);
        check("rst_redirect_pc", 64'(redirect_pc), 64'(VEC));
        rst = 1'b1;
        @(negedge clk);

`ifndef IRQ_EDGE_EN
        // Single permitted request with commit always available: fires on the third edge.
        int_req = 5'b00100; permit_mask = 32'hffff_ffff; commit_valid = 1'b1; commit_pc = 32'h1000;
        repeat (3) @(posedge clk); #1;
        check("t1_exception", 64'(exception), 64'd1);
        check("t1_cause", 64'(cause), 64'h8000_0400);
        check("t1_epc", 64'(epc), 64'h1000);
        check("t1_ack", 64'(int_ack), 64'b00100);
        eret_pulse();

        // Device 0 refused, device 1 permitted.
        int_req = 5'b00011; permit_mask = 32'h2; commit_valid = 1'b1; commit_pc = 32'h1100;
        @(posedge clk); #1; check("t2_dev0", 64'(int_device), 64'd0);
        @(posedge clk); #1; check("t2_dev1", 64'(int_device), 64'd1);
        @(posedge clk);
        @(posedge clk); #1;
        check("t2_exception", 64'(exception), 64'd1);
        check("t2_ack", 64'(int_ack), 64'b00010);
        eret_pulse();

        // Sync exception during arbitration.
        int_req = 5'b00001; permit_mask = 32'd0; commit_valid = 1'b0;
        @(posedge clk);
        @(negedge clk); exc_req = 1'b1; exc_code = 5'd8; exc_pc = 32'h2000;
        @(negedge clk); exc_req = 1'b0;
        @(posedge clk); #1;
        check("t3_exception", 64'(exception), 64'd1);
        check("t3_cause", 64'(cause), 64'h20);
        check("t3_epc", 64'(epc), 64'h2000);
        check("t3_ack", 64'(int_ack), 64'd0);

        // Requests ignored while in service; re-taken after eret.
        @(negedge clk); permit_mask = 32'hffff_ffff; commit_valid = 1'b1; commit_pc = 32'h3000;
        repeat (4) @(negedge clk);
        check("t4_in_service", 64'(in_service), 64'd1);
        eret = 1'b1;
        @(negedge clk); eret = 1'b0;
        repeat (3) @(posedge clk); #1;
        check("t4_retake", 64'(exception), 64'd1);
        check("t4_cause", 64'(cause), 64'h8000_0100);
        eret_pulse();

        // Reset while waiting for commit.
        int_req = 5'b00010; commit_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        check("t5_exception", 64'(exception), 64'd0);
        check("t5_in_service", 64'(in_service), 64'd0);
        check("t5_epc", 64'(epc), 64'd0);
        @(negedge clk); rst = 1'b1; int_req = 5'd0; commit_valid = 1'b1;
        repeat (3) @(negedge clk);
`else
        // One-cycle pulse on line 3 is remembered and survives the line dropping.
        int_req = 5'b01000; permit_mask = 32'hffff_ffff; commit_valid = 1'b0; commit_pc = 32'h4000;
        @(negedge clk); int_req = 5'd0;
        repeat (4) @(negedge clk);
        commit_valid = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(posedge clk); #1;
            if (exception) begin
                seen = 1'b1;
                check("edge_ack", 64'(int_ack), 64'b01000);
            end
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL edge_fire: got no exception expected ack 01000");
        end
        eret_pulse();
`endif

        // Randomized traffic against the reference model.
        for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            rst          = ($urandom_range(0, 149) != 0);
            if ($urandom_range(0, 7) == 0) int_req = 5'($urandom);
            if ($urandom_range(0, 9) == 0) permit_mask = $urandom;
            exc_req      = ($urandom_range(0, 15) == 0);
            exc_code     = 5'($urandom);
            exc_pc       = $urandom;
            commit_valid = $urandom_range(0, 1) != 0;
            commit_pc    = $urandom;
            eret         = ($urandom_range(0, 5) == 0);
        end

        @(negedge clk);
        rst = 1'b1; exc_req = 1'b0; eret = 1'b0; int_req = 5'd0; commit_valid = 1'b1;
        repeat (10) @(negedge clk);
        eret_pulse();
        repeat (5) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
